// File: rtl/if_fetch.sv
`default_nettype none
// if_fetch: instruction fetch with I-cache lookup and a byte-serial refill on a miss.
// Build macro IF_ICACHE_EN enables cache hits and refill writes; undefined, every fetch goes to memory.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        stall_i,
  input  logic        jump_i,
  input  logic [31:0] jump_pc_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [7:0]  mem_data_i,
  output logic [31:0] ic_rpc_o,
  input  logic        ic_hit_i,
  input  logic [31:0] ic_inst_i,
  output logic        ic_we_o,
  output logic [31:0] ic_wpc_o,
  output logic [31:0] ic_winst_o,
  output logic        if_valid_o,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_inst_o
);

  typedef enum logic [1:0] {
    LOOKUP = 2'd0,
    FETCH  = 2'd1,
    WRITE  = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic [1:0]  cnt;
  logic [31:0] buffer;
  logic        cache_hit;
  logic        cache_we_en;

`ifdef IF_ICACHE_EN
  assign cache_hit   = ic_hit_i;
  assign cache_we_en = 1'b1;
`else
  logic unused_hit;
  assign unused_hit  = ic_hit_i;
  assign cache_hit   = 1'b0;
  assign cache_we_en = 1'b0;
`endif

  assign pc_next    = pc + 32'd4;
  assign ic_rpc_o   = pc;
  assign mem_req_o  = (state == FETCH);
  assign mem_addr_o = pc + {30'd0, cnt};
  assign ic_wpc_o   = pc;
  assign ic_winst_o = buffer;
  // The write is qualified by rdy so a frozen WRITE cycle still produces a single pulse.
  assign ic_we_o    = cache_we_en && (state == WRITE) && rdy && !jump_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= LOOKUP;
      pc         <= RESET_PC;
      cnt        <= 2'd0;
      buffer     <= 32'd0;
      if_valid_o <= 1'b0;
      if_pc_o    <= 32'd0;
      if_inst_o  <= 32'd0;
    end else if (rdy) begin
      if (jump_i) begin
        pc         <= jump_pc_i;
        if_valid_o <= 1'b0;
        cnt        <= 2'd0;
        state      <= LOOKUP;
      end else begin
        case (state)
          LOOKUP: begin
            if (!stall_i) begin
              if (cache_hit) begin
                if_valid_o <= 1'b1;
                if_pc_o    <= pc;
                if_inst_o  <= ic_inst_i;
                pc         <= pc_next;
              end else begin
                if_valid_o <= 1'b0;
                cnt        <= 2'd0;
                state      <= FETCH;
              end
            end
          end
          FETCH: begin
            if (mem_ack_i) begin
              buffer[{cnt, 3'b000} +: 8] <= mem_data_i;
              cnt                        <= cnt + 2'd1;
              if (cnt == 2'd3) begin
                state <= WRITE;
              end
            end
          end
          WRITE: begin
            // A stalled WRITE still fills the cache; the retry from LOOKUP then hits.
            if (!stall_i) begin
              if_valid_o <= 1'b1;
              if_pc_o    <= pc;
              if_inst_o  <= buffer;
              pc         <= pc_next;
            end
            state <= LOOKUP;
          end
          default: state <= LOOKUP;
        endcase
      end
    end
  end

endmodule
`default_nettype wire
